// File: rtl/core_pkg.sv
// Shared types and instruction field positions for the single-cycle MIPS core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM16_MSB  = 15;
  localparam int IMM16_LSB  = 0;
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch port: request/address out, ready/data back.
// Latency: memory returns data in the same cycle it asserts ready.
// Backpressure: request and address stay asserted until ready is seen.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  // Fetch side drives the request, memory side answers.
  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_unit_next_pc_logic.sv
// Next-PC selection: sequential, PC-relative branch or pseudo-direct jump.
// Latency: purely combinational.
// Backpressure: none; the caller decides when next_pc_o is consumed.
module next_pc_logic
  import core_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        pcsrc_i,
  input  logic        jump_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic [31:0] jump_tgt;
  logic        unused_opcode_bits;

  assign pc4        = pc_i + INSTR_BYTES;
  // Word offset, sign-extended, scaled to bytes; wraps modulo 2^32.
  assign branch_off = {{14{instr_i[IMM16_MSB]}}, instr_i[IMM16_MSB:IMM16_LSB], 2'b00};
  // Jump stays inside the 256 MB region of the delay-free successor address.
  assign jump_tgt   = {pc4[31:28], instr_i[JADDR_MSB:JADDR_LSB], 2'b00};

  assign unused_opcode_bits = ^instr_i[OPCODE_MSB:OPCODE_LSB];

  // Jump beats branch when the controller raises both.
  always_comb begin
    next_pc_o = pc4;
    if (jump_i) begin
      next_pc_o = jump_tgt;
    end else if (pcsrc_i) begin
      next_pc_o = pc4 + branch_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches over req/ready, holds instr for the controller.
// Latency: 2 cycles per instruction minimum (one FETCH with immediate ready, one EXEC).
// Backpressure: FETCH waits on imem_ready; EXEC holds everything while stall is high.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         pcsrc,
  input  logic         jump,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [5:0]   opcode,
  output logic [5:0]   funct,
  output logic [31:0]  pc,
  output logic [31:0]  retire_count
);

  // Low address bits are meaningless for word fetches, so drop them.
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  retire_q, retire_d;
  logic [31:0]  next_pc;
  logic         fetch_req;
  logic         exec_vld;

  next_pc_logic u_next_pc (
    .pc_i      (pc_q),
    .instr_i   (instr_q),
    .pcsrc_i   (pcsrc),
    .jump_i    (jump),
    .next_pc_o (next_pc)
  );

  // State, PC, instruction and retire counter; reset aborts any fetch in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC_W;
      instr_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      retire_q <= retire_d;
    end
  end

  // Next-state and handshake outputs; everything holds unless a case says otherwise.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retire_d  = retire_q;
    fetch_req = 1'b0;
    exec_vld  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec_vld = 1'b1;
        if (!stall) begin
          pc_d     = next_pc;
          retire_d = retire_q + 32'd1;
          state_d  = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = pc_q;

  assign instr_valid  = exec_vld;
  assign instr        = instr_q;
  assign opcode       = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign funct        = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign pc           = pc_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three instances with different reset PCs share the stimulus.
// Expected fetch addresses are queued when an instruction retires and popped at the next fetch.
module tb_fetch_unit;

  localparam logic [31:0] RST_PCS [3] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h4000_0013};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic        jump = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;

  logic        req_w   [3];
  logic [31:0] addr_w  [3];
  logic        vld_w   [3];
  logic [31:0] instr_w [3];
  logic [5:0]  op_w    [3];
  logic [5:0]  fn_w    [3];
  logic [31:0] pc_w    [3];
  logic [31:0] ret_w   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fetch_unit_if bus ();
    assign bus.imem_ready = imem_ready;
    assign bus.imem_rdata = imem_rdata;
    assign req_w[g]  = bus.imem_req;
    assign addr_w[g] = bus.imem_addr;
    fetch_unit #(.RESET_PC(RST_PCS[g])) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem         (bus),
      .stall        (stall),
      .pcsrc        (pcsrc),
      .jump         (jump),
      .instr_valid  (vld_w[g]),
      .instr        (instr_w[g]),
      .opcode       (op_w[g]),
      .funct        (fn_w[g]),
      .pc           (pc_w[g]),
      .retire_count (ret_w[g])
    );
  end

  int sel = 0;
  logic        o_req, o_vld;
  logic [31:0] o_addr, o_instr, o_pc, o_ret;
  logic [5:0]  o_op, o_fn;
  assign o_req   = req_w[sel];
  assign o_addr  = addr_w[sel];
  assign o_vld   = vld_w[sel];
  assign o_instr = instr_w[sel];
  assign o_op    = op_w[sel];
  assign o_fn    = fn_w[sel];
  assign o_pc    = pc_w[sel];
  assign o_ret   = ret_w[sel];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] n_ret = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic pop_exp(output logic [31:0] v);
    if (exp_q.size() == 0) begin
      check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
      v = '0;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  // Called at a negedge; leaves the DUT in its first FETCH cycle, at a negedge.
  task automatic do_reset(input int s, input logic [31:0] start);
    rst_n = 1'b0;
    imem_ready = 1'b0;
    stall = 1'b0;
    pcsrc = 1'b0;
    jump = 1'b0;
    sel = s;
    exp_q.delete();
    n_ret = 0;
    @(negedge clk);
    check_eq("rst_req", 32'(o_req), 32'd0);
    check_eq("rst_vld", 32'(o_vld), 32'd0);
    check_eq("rst_pc", o_pc, start);
    check_eq("rst_instr", o_instr, 32'd0);
    check_eq("rst_retire", o_ret, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("idle_req", 32'(o_req), 32'd0);
    exp_q.push_back(start);
    @(negedge clk);
    check_eq("fetch_after_rel", 32'(o_req), 32'd1);
  endtask

  // One instruction: fetch (after nwait not-ready cycles), nstall stall cycles, retire.
  task automatic run_instr(input logic [31:0] word, input logic pcs, input logic jmp,
                           input int nstall, input int nwait, input logic [31:0] nxt);
    logic [31:0] a;
    int g;
    g = 0;
    while (o_req !== 1'b1 && g < 8) begin
      @(negedge clk);
      g++;
    end
    check_eq("fetch_req", 32'(o_req), 32'd1);
    pop_exp(a);
    check_eq("fetch_addr", o_addr, a);
    check_eq("fetch_pc", o_pc, a);
    check_eq("fetch_vld", 32'(o_vld), 32'd0);
    for (int i = 0; i < nwait; i++) begin
      imem_ready = 1'b0;
      imem_rdata = 32'hBAD0_0000 | 32'(i);
      @(negedge clk);
      check_eq("wait_req", 32'(o_req), 32'd1);
      check_eq("wait_addr", o_addr, a);
      check_eq("wait_pc", o_pc, a);
      check_eq("wait_vld", 32'(o_vld), 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check_eq("exec_vld", 32'(o_vld), 32'd1);
    check_eq("exec_req", 32'(o_req), 32'd0);
    check_eq("exec_instr", o_instr, word);
    check_eq("exec_opcode", 32'(o_op), 32'(word[31:26]));
    check_eq("exec_funct", 32'(o_fn), 32'(word[5:0]));
    check_eq("exec_pc", o_pc, a);
    for (int i = 0; i < nstall; i++) begin
      stall = 1'b1;
      pcsrc = i[0];
      jump = ~i[0];
      @(negedge clk);
      check_eq("stall_instr", o_instr, word);
      check_eq("stall_pc", o_pc, a);
      check_eq("stall_retire", o_ret, n_ret);
      check_eq("stall_vld", 32'(o_vld), 32'd1);
    end
    stall = 1'b0;
    pcsrc = pcs;
    jump = jmp;
    exp_q.push_back(nxt);
    n_ret = n_ret + 32'd1;
    @(negedge clk);
    pcsrc = 1'b0;
    jump = 1'b0;
    check_eq("retire", o_ret, n_ret);
    check_eq("retire_vld", 32'(o_vld), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int c0;
    logic [31:0] a;
    int g;
    #3 rst_n = 1'b0;
    do_reset(0, 32'h0);

    // Straight-line code, memory always ready.
    c0 = cyc;
    run_instr(32'h0022_1820, 1'b0, 1'b0, 0, 0, 32'h4);
    run_instr(32'h2042_0005, 1'b0, 1'b0, 0, 0, 32'h8);
    run_instr(32'h8C43_0010, 1'b0, 1'b0, 0, 0, 32'hC);
    run_instr(32'hAC43_0014, 1'b0, 1'b0, 0, 0, 32'h10);
    check_eq("cycles_for_4", 32'(cyc - c0), 32'd8);
    check_eq("retire_4", o_ret, 32'd4);

    // Jump back to 8, then a slow fetch there that jumps to 0x100.
    run_instr({6'h02, 26'h000_0002}, 1'b0, 1'b1, 0, 0, 32'h8);
    run_instr({6'h02, 26'h000_0040}, 1'b0, 1'b1, 0, 3, 32'h100);

    // Backward branch, stalled instruction, forward branch, jump to 0x20.
    run_instr({6'h04, 5'd1, 5'd2, 16'hFFFE}, 1'b1, 1'b0, 0, 0, 32'h0FC);
    run_instr(32'h0000_0820, 1'b0, 1'b0, 5, 0, 32'h100);
    run_instr({6'h04, 5'd1, 5'd2, 16'h0003}, 1'b1, 1'b0, 0, 0, 32'h110);
    run_instr({6'h02, 26'h000_0008}, 1'b0, 1'b1, 0, 0, 32'h20);

    // Reset lands in the middle of the fetch at 0x20.
    g = 0;
    while (o_req !== 1'b1 && g < 8) begin
      @(negedge clk);
      g++;
    end
    pop_exp(a);
    check_eq("pre_rst_addr", o_addr, a);
    imem_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_req", 32'(o_req), 32'd0);
    check_eq("async_pc", o_pc, 32'h0);
    check_eq("async_vld", 32'(o_vld), 32'd0);
    check_eq("async_retire", o_ret, 32'd0);
    do_reset(0, 32'h0);
    run_instr(32'h0000_0000, 1'b0, 1'b0, 0, 0, 32'h4);

    // Reset PC at the top of memory: sequential wrap and negative branch wrap.
    do_reset(1, 32'hFFFF_FFFC);
    run_instr(32'h2042_0001, 1'b0, 1'b0, 0, 0, 32'h0);
    run_instr({6'h04, 5'd3, 5'd4, 16'hFFFE}, 1'b1, 1'b0, 0, 0, 32'hFFFF_FFFC);
    run_instr(32'h2042_0002, 1'b0, 1'b0, 0, 0, 32'h0);

    // Unaligned reset PC; jump and branch together, jump wins.
    do_reset(2, 32'h4000_0010);
    run_instr({6'h02, 26'h000_0040}, 1'b1, 1'b1, 0, 0, 32'h4000_0100);
    run_instr(32'h0000_0020, 1'b0, 1'b0, 0, 1, 32'h4000_0104);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
